// File: rtl/mem_bus_decoder.sv
// Address decoder for a req/gnt memory bus fanning out to NUM_SLAVES ports.
// An in-order response FIFO routes read data back and synthesises error replies for unmapped accesses.
module mem_bus_decoder #(
  parameter int NUM_SLAVES      = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE = {32'h0004_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK = {32'hFFFF_F000, 32'hFFFF_FC00}
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 m_req_i,
  output logic                                 m_gnt_o,
  input  logic [ADDR_WIDTH-1:0]                m_addr_i,
  input  logic                                 m_we_i,
  input  logic [DATA_WIDTH/8-1:0]              m_be_i,
  input  logic [DATA_WIDTH-1:0]                m_wdata_i,
  output logic                                 m_rvalid_o,
  output logic [DATA_WIDTH-1:0]                m_rdata_o,
  output logic                                 m_err_o,
  output logic [NUM_SLAVES-1:0]                s_req_o,
  input  logic [NUM_SLAVES-1:0]                s_gnt_i,
  output logic [ADDR_WIDTH-1:0]                s_addr_o,
  output logic                                 s_we_o,
  output logic [DATA_WIDTH/8-1:0]              s_be_o,
  output logic [DATA_WIDTH-1:0]                s_wdata_o,
  input  logic [NUM_SLAVES-1:0]                s_rvalid_i,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0]     s_rdata_i,
  input  logic [NUM_SLAVES-1:0]                s_err_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 proto_err_o
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int ENT_W = IDX_W + 1;

  logic                  w_hit;
  logic [IDX_W-1:0]      w_hitIdx;
  logic                  w_hitGnt;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_stray;
  logic [ENT_W-1:0]      w_head;
  logic                  w_headUnmapped;
  logic [IDX_W-1:0]      w_headIdx;
  logic [NUM_SLAVES-1:0] w_headMask;

  logic [ENT_W-1:0]      r_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      r_wrPtr;
  logic [PTR_W-1:0]      r_rdPtr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_protoErr;

  assign s_addr_o  = m_addr_i;
  assign s_we_o    = m_we_i;
  assign s_be_o    = m_be_i;
  assign s_wdata_o = m_wdata_i;

  // Scan from the top so the lowest matching slave is the one left standing.
  always_comb begin
    w_hit    = 1'b0;
    w_hitIdx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_addr_i & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        w_hit    = 1'b1;
        w_hitIdx = IDX_W'(i);
      end
    end
  end

  assign w_full  = (r_count == CNT_W'(MAX_OUTSTANDING));
  assign w_empty = (r_count == '0);

  always_comb begin
    s_req_o  = '0;
    w_hitGnt = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (w_hit && (w_hitIdx == IDX_W'(i))) begin
        s_req_o[i] = m_req_i && !w_full;
        w_hitGnt   = s_gnt_i[i];
      end
    end
    m_gnt_o = !w_full && (w_hit ? w_hitGnt : 1'b1);
  end

  assign w_push         = m_req_i && m_gnt_o;
  assign w_head         = r_mem[r_rdPtr];
  assign w_headUnmapped = w_head[IDX_W];
  assign w_headIdx      = w_head[IDX_W-1:0];

  // An unmapped head answers by itself for one cycle; a mapped head waits for its slave.
  always_comb begin
    m_rvalid_o = 1'b0;
    m_rdata_o  = '0;
    m_err_o    = 1'b0;
    w_pop      = 1'b0;
    w_headMask = '0;
    if (!w_empty) begin
      if (w_headUnmapped) begin
        m_rvalid_o = 1'b1;
        m_err_o    = 1'b1;
        w_pop      = 1'b1;
      end else begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
          if (w_headIdx == IDX_W'(i)) begin
            w_headMask[i] = 1'b1;
            if (s_rvalid_i[i]) begin
              m_rvalid_o = 1'b1;
              m_rdata_o  = s_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
              m_err_o    = s_err_i[i];
              w_pop      = 1'b1;
            end
          end
        end
      end
    end
  end

  assign w_stray = w_empty ? (|s_rvalid_i) : (|(s_rvalid_i & ~w_headMask));

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= {!w_hit, w_hitIdx};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_protoErr <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= (r_wrPtr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= (r_rdPtr == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : r_rdPtr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
      if (w_stray) begin
        r_protoErr <= 1'b1;
      end
    end
  end

  assign outstanding_o = r_count;
  assign proto_err_o   = r_protoErr;

endmodule

// File: tb/tb_mem_bus_decoder.sv
// Bench for mem_bus_decoder: decode vector table plus ordering, full-stall and reset sequences.
// Responses are checked by a negedge monitor against a queue of expected replies.
module tb_mem_bus_decoder;

  localparam int NS = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 2;
  localparam int BW = DW / 8;
  localparam int CW = $clog2(MO + 1);

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           m_req_i;
  logic           m_gnt_o;
  logic [AW-1:0]  m_addr_i;
  logic           m_we_i;
  logic [BW-1:0]  m_be_i;
  logic [DW-1:0]  m_wdata_i;
  logic           m_rvalid_o;
  logic [DW-1:0]  m_rdata_o;
  logic           m_err_o;
  logic [NS-1:0]  s_req_o;
  logic [NS-1:0]  s_gnt_i;
  logic [AW-1:0]  s_addr_o;
  logic           s_we_o;
  logic [BW-1:0]  s_be_o;
  logic [DW-1:0]  s_wdata_o;
  logic [NS-1:0]  s_rvalid_i;
  logic [NS*DW-1:0] s_rdata_i;
  logic [NS-1:0]  s_err_i;
  logic [CW-1:0]  outstanding_o;
  logic           proto_err_o;

  always #5 clk_i = ~clk_i;

  mem_bus_decoder #(
    .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_req_i(m_req_i), .m_gnt_o(m_gnt_o), .m_addr_i(m_addr_i), .m_we_i(m_we_i),
    .m_be_i(m_be_i), .m_wdata_i(m_wdata_i), .m_rvalid_o(m_rvalid_o),
    .m_rdata_o(m_rdata_o), .m_err_o(m_err_o),
    .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
    .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_rvalid_i(s_rvalid_i),
    .s_rdata_i(s_rdata_i), .s_err_i(s_err_i),
    .outstanding_o(outstanding_o), .proto_err_o(proto_err_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  sGnt;
    logic [1:0]  sErr;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [1:0]  expSReq;
    logic        expGnt;
    logic [31:0] expRdata;
    logic        expErr;
  } vec_t;

  vec_t        vecs [8];
  logic [32:0] expQ [$];
  logic [32:0] expResp;
  int          assertCount = 0;
  int          failCount   = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    m_req_i    = 1'b0;
    s_gnt_i    = '0;
    s_rvalid_i = '0;
    s_err_i    = '0;
    s_rdata_i  = '0;
  endtask

  task automatic driveReq(input logic [31:0] addr, input logic [1:0] gnt);
    m_req_i  = 1'b1;
    m_addr_i = addr;
    s_gnt_i  = gnt;
  endtask

  task automatic pushExp(input logic [31:0] rdata, input logic err);
    expQ.push_back({err, rdata});
  endtask

  // One complete transfer: request, decode checks, then the slave reply if one is owed.
  task automatic applyStimulus(input vec_t v, input int n);
    tick();
    driveReq(v.addr, v.sGnt);
    m_we_i    = v.we;
    m_be_i    = v.be;
    m_wdata_i = v.wdata;
    #2;
    checkOutput($sformatf("vec%0d s_req", n), 64'(s_req_o), 64'(v.expSReq));
    checkOutput($sformatf("vec%0d m_gnt", n), 64'(m_gnt_o), 64'(v.expGnt));
    checkOutput($sformatf("vec%0d s_addr", n), 64'(s_addr_o), 64'(v.addr));
    checkOutput($sformatf("vec%0d s_we/be/wdata", n), {27'b0, s_we_o, s_be_o, s_wdata_o},
                {27'b0, v.we, v.be, v.wdata});
    if (v.expGnt) pushExp(v.expRdata, v.expErr);
    tick();
    idle();
    if (v.expGnt) begin
      checkOutput($sformatf("vec%0d outstanding after accept", n), 64'(outstanding_o), 64'd1);
      if (v.expSReq != '0) begin
        s_rvalid_i = v.expSReq;
        s_err_i    = v.sErr;
        s_rdata_i  = {v.rd1, v.rd0};
      end
      tick();
      idle();
    end
    checkOutput($sformatf("vec%0d outstanding drained", n), 64'(outstanding_o), 64'd0);
    checkOutput($sformatf("vec%0d proto_err", n), 64'(proto_err_o), 64'd0);
  endtask

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (m_rvalid_o) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected m_rvalid", 64'(m_rvalid_o), 64'd0);
        end else begin
          expResp = expQ.pop_front();
          checkOutput("resp rdata", 64'(m_rdata_o), 64'(expResp[31:0]));
          checkOutput("resp err", 64'(m_err_o), 64'(expResp[32]));
        end
      end else begin
        checkOutput("idle rdata/err", {31'b0, m_err_o, m_rdata_o}, 64'd0);
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{32'h0000_0010, 1'b0, 4'hF, 32'h0,         2'b01, 2'b00, 32'hDEAD_BEEF, 32'h1111_1111, 2'b01, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{32'h0004_0080, 1'b0, 4'hF, 32'h0,         2'b10, 2'b00, 32'h0BAD_BAD0, 32'hCAFE_F00D, 2'b10, 1'b1, 32'hCAFE_F00D, 1'b0};
    vecs[2] = '{32'h0010_0000, 1'b1, 4'h3, 32'hA5A5_A5A5, 2'b11, 2'b00, 32'h5555_5555, 32'h6666_6666, 2'b00, 1'b1, 32'h0,         1'b1};
    vecs[3] = '{32'h0000_03FC, 1'b1, 4'hC, 32'h1234_0000, 2'b00, 2'b00, 32'h0,         32'h0,         2'b01, 1'b0, 32'h0,         1'b0};
    vecs[4] = '{32'h0000_0400, 1'b0, 4'h1, 32'h0000_00FF, 2'b01, 2'b00, 32'h7777_7777, 32'h0,         2'b00, 1'b1, 32'h0,         1'b1};
    vecs[5] = '{32'h0004_0FFC, 1'b0, 4'hF, 32'h0,         2'b10, 2'b10, 32'h9999_9999, 32'h1234_5678, 2'b10, 1'b1, 32'h1234_5678, 1'b1};
    vecs[6] = '{32'h0004_1000, 1'b1, 4'h8, 32'hFEED_0000, 2'b10, 2'b00, 32'h0,         32'h0,         2'b00, 1'b1, 32'h0,         1'b1};
    vecs[7] = '{32'h0004_0010, 1'b0, 4'hF, 32'h0,         2'b01, 2'b00, 32'h0,         32'h0,         2'b10, 1'b0, 32'h0,         1'b0};

    rst_ni    = 1'b0;
    m_addr_i  = '0;
    m_we_i    = 1'b0;
    m_be_i    = '0;
    m_wdata_i = '0;
    idle();
    #3;
    checkOutput("reset outstanding", 64'(outstanding_o), 64'd0);
    checkOutput("reset proto_err", 64'(proto_err_o), 64'd0);
    checkOutput("reset rvalid/err/rdata", {31'b0, m_rvalid_o, m_err_o, m_rdata_o}, 64'd0);
    tick();
    tick();
    rst_ni = 1'b1;

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

    // Slave 0 answers out of turn: ignored and flagged, then both replies come back in order.
    tick();
    driveReq(32'h0004_0000, 2'b10);
    pushExp(32'hAAAA_0001, 1'b0);
    tick();
    driveReq(32'h0000_0020, 2'b01);
    pushExp(32'hBBBB_0002, 1'b0);
    tick();
    idle();
    checkOutput("order outstanding", 64'(outstanding_o), 64'd2);
    s_rvalid_i = 2'b01;
    s_rdata_i  = {32'h0, 32'hBBBB_0002};
    #2;
    checkOutput("order early rvalid ignored", 64'(m_rvalid_o), 64'd0);
    tick();
    checkOutput("order proto_err set", 64'(proto_err_o), 64'd1);
    s_rvalid_i = 2'b10;
    s_rdata_i  = {32'hAAAA_0001, 32'h0};
    tick();
    s_rvalid_i = 2'b01;
    s_rdata_i  = {32'h0, 32'hBBBB_0002};
    tick();
    idle();
    checkOutput("order drained", 64'(outstanding_o), 64'd0);
    checkOutput("order proto_err sticky", 64'(proto_err_o), 64'd1);

    rst_ni = 1'b0;
    #2;
    checkOutput("reset clears proto_err", 64'(proto_err_o), 64'd0);
    tick();
    rst_ni = 1'b1;

    // Full FIFO stalls a third request even while the head pops in the same cycle.
    tick();
    driveReq(32'h0000_0000, 2'b01);
    pushExp(32'h1111_0001, 1'b0);
    tick();
    driveReq(32'h0004_0000, 2'b10);
    pushExp(32'h2222_0002, 1'b0);
    tick();
    driveReq(32'h0000_0100, 2'b01);
    s_rvalid_i = 2'b01;
    s_rdata_i  = {32'h0, 32'h1111_0001};
    #2;
    checkOutput("full m_gnt", 64'(m_gnt_o), 64'd0);
    checkOutput("full s_req", 64'(s_req_o), 64'd0);
    checkOutput("full outstanding", 64'(outstanding_o), 64'd2);
    tick();
    s_rvalid_i = 2'b10;
    s_rdata_i  = {32'h2222_0002, 32'h0};
    #2;
    checkOutput("after pop m_gnt", 64'(m_gnt_o), 64'd1);
    checkOutput("after pop s_req", 64'(s_req_o), 64'd1);
    pushExp(32'h3333_0003, 1'b0);
    tick();
    idle();
    checkOutput("push+pop outstanding", 64'(outstanding_o), 64'd1);
    s_rvalid_i = 2'b01;
    s_rdata_i  = {32'h0, 32'h3333_0003};
    tick();
    idle();
    checkOutput("full seq drained", 64'(outstanding_o), 64'd0);
    checkOutput("full seq proto_err", 64'(proto_err_o), 64'd0);

    // Reset with two in flight drops them; a late reply is then a protocol error.
    tick();
    driveReq(32'h0000_0008, 2'b01);
    pushExp(32'h4444_0004, 1'b0);
    tick();
    driveReq(32'h0004_0004, 2'b10);
    pushExp(32'h5555_0005, 1'b0);
    tick();
    idle();
    checkOutput("pre-reset outstanding", 64'(outstanding_o), 64'd2);
    rst_ni = 1'b0;
    #1;
    checkOutput("mid reset outstanding", 64'(outstanding_o), 64'd0);
    checkOutput("mid reset rvalid", 64'(m_rvalid_o), 64'd0);
    expQ.delete();
    tick();
    rst_ni     = 1'b1;
    s_rvalid_i = 2'b01;
    s_rdata_i  = {32'h0, 32'h4444_0004};
    #2;
    checkOutput("late reply rvalid", {31'b0, m_rvalid_o, m_rdata_o}, 64'd0);
    tick();
    idle();
    checkOutput("late reply proto_err", 64'(proto_err_o), 64'd1);
    checkOutput("late reply outstanding", 64'(outstanding_o), 64'd0);

    tick();
    checkOutput("expected responses consumed", 64'(expQ.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
